// File: rtl/rgmii_rx_frame_buffer.sv
// Store-and-forward receive frame buffer (clk125 domain).
// Collects a gappy RGMII byte stream into a RAM and replays each committed
// frame as a contiguous burst with a programmable inter-frame gap. Aborted,
// overflowed and (optionally) errored frames are dropped and counted.
module rgmii_rx_frame_buffer #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 11,
   parameter int DESC_W   = 4,
   parameter int DROP_ERR = 1,
   parameter int IFG      = 12
) (
   input  logic              clk125,
   input  logic              s_aresetn,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_val,
   input  logic              in_sof,
   input  logic              in_eof,
   input  logic              in_err,
   output logic [DATA_W-1:0] out_data,
   output logic              out_val,
   output logic              out_sof,
   output logic              out_eof,
   output logic              out_err,
   output logic [15:0]       frame_cnt,
   output logic [15:0]       drop_cnt,
   output logic [15:0]       gap_cnt,
   output logic [ADDR_W:0]   level
);

   localparam int DEPTH  = 2**ADDR_W;
   localparam int DDEPTH = 2**DESC_W;
   localparam logic [ADDR_W:0] FULL_LVL = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [15:0] IFG_LAST = (IFG > 0) ? 16'(IFG - 1) : 16'd0;

   typedef enum logic [1:0] {W_IDLE, W_FRAME, W_DISCARD} wstate_t;
   typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND, R_GAP} rstate_t;

   wstate_t wstate, wstate_nxt;
   rstate_t rstate, rstate_nxt;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] ram_q;

   logic [ADDR_W:0]   wr_ptr, wr_ptr_nxt;
   logic [ADDR_W:0]   commit_ptr, commit_ptr_nxt;
   logic [ADDR_W:0]   rd_ptr, rd_ptr_nxt;
   logic [ADDR_W:0]   len_r, len_nxt;
   logic              err_r, err_nxt;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic              push;
   logic [1:0]        drop_add;
   logic              gap_inc;
   logic              accept;
   logic [ADDR_W:0]   base;
   logic [ADDR_W:0]   base_lvl;
   logic [ADDR_W:0]   cur_len;
   logic              cur_err;
   logic              frame_err;

   logic [ADDR_W:0]   desc_len [DDEPTH];
   logic              desc_err [DDEPTH];
   logic [DESC_W-1:0] desc_wp, desc_rp;
   logic [DESC_W:0]   desc_cnt;
   logic              desc_full, desc_empty;

   logic [ADDR_W:0]   rlen, rlen_nxt;
   logic [ADDR_W:0]   bcnt, bcnt_nxt;
   logic              rerr, rerr_nxt;
   logic [15:0]       ifg_cnt, ifg_nxt;
   logic              pop;
   logic              frame_inc;
   logic              send_last;

   assign desc_full  = desc_cnt[DESC_W];
   assign desc_empty = (desc_cnt == '0);
   assign level      = wr_ptr - rd_ptr;

   // Write side: frame assembly, overflow/abort handling and commit decision.
   always_comb begin
      wstate_nxt     = wstate;
      wr_ptr_nxt     = wr_ptr;
      commit_ptr_nxt = commit_ptr;
      len_nxt        = len_r;
      err_nxt        = err_r;
      wr_en          = 1'b0;
      wr_addr        = wr_ptr[ADDR_W-1:0];
      push           = 1'b0;
      drop_add       = '0;
      gap_inc        = 1'b0;
      accept         = 1'b0;
      base           = wr_ptr;
      cur_len        = len_r;
      cur_err        = err_r;
      base_lvl       = '0;
      frame_err      = 1'b0;
      case (wstate)
         W_IDLE: begin
            if (in_val && in_sof) begin
               accept  = 1'b1;
               base    = commit_ptr;
               cur_len = '0;
               cur_err = 1'b0;
            end
         end
         W_FRAME: begin
            if (in_val) begin
               accept = 1'b1;
               if (in_sof) begin
                  drop_add = 2'd1;
                  base     = commit_ptr;
                  cur_len  = '0;
                  cur_err  = 1'b0;
               end
            end else begin
               gap_inc = 1'b1;
            end
         end
         W_DISCARD: begin
            if (in_val && in_sof) begin
               drop_add = 2'd1;
               accept   = 1'b1;
               base     = commit_ptr;
               cur_len  = '0;
               cur_err  = 1'b0;
            end else if (in_val && in_eof) begin
               drop_add   = 2'd1;
               wstate_nxt = W_IDLE;
            end
         end
         default: wstate_nxt = W_IDLE;
      endcase
      if (accept) begin
         frame_err = cur_err | in_err;
         base_lvl  = base - rd_ptr;
         if (base_lvl == FULL_LVL) begin
            // overflow: space is released now, the drop is counted at frame end
            wr_ptr_nxt = commit_ptr;
            if (in_eof) begin
               drop_add   = drop_add + 2'd1;
               wstate_nxt = W_IDLE;
            end else begin
               wstate_nxt = W_DISCARD;
            end
         end else begin
            wr_en      = 1'b1;
            wr_addr    = base[ADDR_W-1:0];
            wr_ptr_nxt = base + 1'b1;
            len_nxt    = cur_len + 1'b1;
            err_nxt    = frame_err;
            if (in_eof) begin
               wstate_nxt = W_IDLE;
               if ((frame_err && DROP_ERR != 0) || desc_full) begin
                  wr_ptr_nxt = commit_ptr;
                  drop_add   = drop_add + 2'd1;
               end else begin
                  commit_ptr_nxt = base + 1'b1;
                  push           = 1'b1;
               end
            end else begin
               wstate_nxt = W_FRAME;
            end
         end
      end
   end

   // Read side: descriptor pop, RAM prefetch, burst playback, inter-frame gap.
   always_comb begin
      rstate_nxt = rstate;
      rd_ptr_nxt = rd_ptr;
      rlen_nxt   = rlen;
      rerr_nxt   = rerr;
      bcnt_nxt   = bcnt;
      ifg_nxt    = ifg_cnt;
      pop        = 1'b0;
      frame_inc  = 1'b0;
      out_val    = 1'b0;
      out_sof    = 1'b0;
      out_eof    = 1'b0;
      out_err    = 1'b0;
      out_data   = '0;
      send_last  = (bcnt == rlen - 1'b1);
      case (rstate)
         R_IDLE: begin
            if (!desc_empty) begin
               pop        = 1'b1;
               rstate_nxt = R_LOAD;
            end
         end
         R_LOAD: begin
            rd_ptr_nxt = rd_ptr + 1'b1;
            bcnt_nxt   = '0;
            rstate_nxt = R_SEND;
         end
         R_SEND: begin
            out_val  = 1'b1;
            out_data = ram_q;
            out_sof  = (bcnt == '0);
            out_eof  = send_last;
            out_err  = send_last & rerr;
            if (send_last) begin
               frame_inc = 1'b1;
               if (IFG == 0) begin
                  if (!desc_empty) begin
                     pop        = 1'b1;
                     rstate_nxt = R_LOAD;
                  end else begin
                     rstate_nxt = R_IDLE;
                  end
               end else begin
                  ifg_nxt    = '0;
                  rstate_nxt = R_GAP;
               end
            end else begin
               bcnt_nxt   = bcnt + 1'b1;
               rd_ptr_nxt = rd_ptr + 1'b1;
            end
         end
         R_GAP: begin
            // last gap cycle pops directly so the next sof lands at eof+IFG+2
            if (ifg_cnt == IFG_LAST) begin
               if (!desc_empty) begin
                  pop        = 1'b1;
                  rstate_nxt = R_LOAD;
               end else begin
                  rstate_nxt = R_IDLE;
               end
            end else begin
               ifg_nxt = ifg_cnt + 1'b1;
            end
         end
         default: rstate_nxt = R_IDLE;
      endcase
      if (pop) begin
         rlen_nxt = desc_len[desc_rp];
         rerr_nxt = desc_err[desc_rp];
      end
   end

   // Frame RAM and descriptor storage; contents need no reset.
   always_ff @(posedge clk125) begin
      if (wr_en) mem[wr_addr] <= in_data;
      ram_q <= mem[rd_ptr[ADDR_W-1:0]];
      if (push) begin
         desc_len[desc_wp] <= len_nxt;
         desc_err[desc_wp] <= err_nxt;
      end
   end

   // State, pointers and descriptor bookkeeping.
   always_ff @(posedge clk125 or negedge s_aresetn) begin
      if (!s_aresetn) begin
         wstate     <= W_IDLE;
         rstate     <= R_IDLE;
         wr_ptr     <= '0;
         commit_ptr <= '0;
         rd_ptr     <= '0;
         len_r      <= '0;
         err_r      <= 1'b0;
         rlen       <= '0;
         rerr       <= 1'b0;
         bcnt       <= '0;
         ifg_cnt    <= '0;
         desc_wp    <= '0;
         desc_rp    <= '0;
         desc_cnt   <= '0;
      end else begin
         wstate     <= wstate_nxt;
         rstate     <= rstate_nxt;
         wr_ptr     <= wr_ptr_nxt;
         commit_ptr <= commit_ptr_nxt;
         rd_ptr     <= rd_ptr_nxt;
         len_r      <= len_nxt;
         err_r      <= err_nxt;
         rlen       <= rlen_nxt;
         rerr       <= rerr_nxt;
         bcnt       <= bcnt_nxt;
         ifg_cnt    <= ifg_nxt;
         if (push) desc_wp <= desc_wp + 1'b1;
         if (pop)  desc_rp <= desc_rp + 1'b1;
         case ({push, pop})
            2'b10:   desc_cnt <= desc_cnt + 1'b1;
            2'b01:   desc_cnt <= desc_cnt - 1'b1;
            default: desc_cnt <= desc_cnt;
         endcase
      end
   end

   // Saturating statistics counters.
   always_ff @(posedge clk125 or negedge s_aresetn) begin
      if (!s_aresetn) begin
         frame_cnt <= '0;
         drop_cnt  <= '0;
         gap_cnt   <= '0;
      end else begin
         if (frame_inc && frame_cnt != '1) frame_cnt <= frame_cnt + 1'b1;
         if (gap_inc && gap_cnt != '1)     gap_cnt   <= gap_cnt + 1'b1;
         if (drop_add != '0) begin
            if (drop_cnt > 16'hFFFF - 16'(drop_add)) drop_cnt <= '1;
            else                                      drop_cnt <= drop_cnt + 16'(drop_add);
         end
      end
   end

endmodule
